// File: rtl/seven_seg_pkg.sv
// ============================================================================
// Module      : seven_seg_pkg
// Description : Segment bit order, hex glyph table and blank glyph shared by
//               the seven-segment reader.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package seven_seg_pkg;

  // Segment lines are active-low, packed a..g from bit 6 down to bit 0.
  typedef enum logic [2:0] {
    SEG_G = 3'd0,
    SEG_F = 3'd1,
    SEG_E = 3'd2,
    SEG_D = 3'd3,
    SEG_C = 3'd4,
    SEG_B = 3'd5,
    SEG_A = 3'd6
  } seg_bit_e;

  localparam logic [6:0] c_seg_blank = 7'h7F;

  localparam logic [6:0] c_seg_hex [16] = '{
    7'h01, 7'h4F, 7'h12, 7'h06,
    7'h4C, 7'h24, 7'h20, 7'h0F,
    7'h00, 7'h04, 7'h08, 7'h60,
    7'h31, 7'h42, 7'h30, 7'h38
  };

endpackage

`default_nettype wire

// File: rtl/seven_segment_reader_seg7_to_hex.sv
// ============================================================================
// Module      : seg7_to_hex
// Description : Combinational decode of an active-low 7-segment glyph into a
//               hex nibble with legal and blank flags.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg7_to_hex
  import seven_seg_pkg::*;
(
  input  logic [6:0] i_pattern,
  output logic [3:0] o_nibble,
  output logic       o_legal,
  output logic       o_blank
);

  always_comb begin
    o_nibble = 4'h0;
    o_legal  = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (i_pattern == c_seg_hex[i]) begin
        o_nibble = 4'(i);
        o_legal  = 1'b1;
      end
    end
  end

  assign o_blank = (i_pattern == c_seg_blank);

endmodule

`default_nettype wire

// File: rtl/seven_segment_reader.sv
// ============================================================================
// Module      : seven_segment_reader
// Description : Reconstructs a hex frame from a multiplexed active-low
//               7-segment display bus. Define SEVEN_SEG_READER_SYNC_EN to add
//               a two-flop input synchronizer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seven_segment_reader
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_DIGITS-1:0]         an_in,
  input  logic [6:0]                    seg_in,
  output logic [4*NUM_DIGITS-1:0]       value_out,
  output logic                          valid_out,
  output logic                          err_out,
  output logic [$clog2(NUM_DIGITS)-1:0] err_digit
);

  localparam int                    c_idx_w  = $clog2(NUM_DIGITS);
  localparam logic [7:0]            c_stable = 8'(STABLE_CYCLES);
  localparam logic [NUM_DIGITS-1:0] c_one    = NUM_DIGITS'(1);

  logic [NUM_DIGITS-1:0]   w_an;
  logic [6:0]              w_seg;

  logic [NUM_DIGITS-1:0]   r_prev_an;
  logic [6:0]              r_prev_seg;
  logic [7:0]              r_cnt;
  logic [7:0]              w_cnt_next;
  logic                    r_hit;

  logic [NUM_DIGITS-1:0]   w_low;
  logic                    w_active;
  logic                    w_same;
  logic [c_idx_w-1:0]      w_idx;

  logic [3:0]              w_nibble;
  logic                    w_legal;
  logic                    w_blank;

  logic [NUM_DIGITS-1:0]   r_captured;
  logic [NUM_DIGITS-1:0]   w_captured_next;
  logic [4*NUM_DIGITS-1:0] r_slots;
  logic [4*NUM_DIGITS-1:0] r_value;
  logic                    r_valid;
  logic                    r_err;
  logic [c_idx_w-1:0]      r_err_digit;

  logic                    w_frame_done;
  logic                    w_capture;
  logic                    w_illegal;

`ifdef SEVEN_SEG_READER_SYNC_EN
  logic [NUM_DIGITS-1:0] r_an_meta;
  logic [NUM_DIGITS-1:0] r_an_sync;
  logic [6:0]            r_seg_meta;
  logic [6:0]            r_seg_sync;

  // Idle bus level (all lines high) keeps the reader quiet coming out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_an_meta  <= '1;
      r_an_sync  <= '1;
      r_seg_meta <= '1;
      r_seg_sync <= '1;
    end else begin
      r_an_meta  <= an_in;
      r_an_sync  <= r_an_meta;
      r_seg_meta <= seg_in;
      r_seg_sync <= r_seg_meta;
    end
  end

  assign w_an  = r_an_sync;
  assign w_seg = r_seg_sync;
`else
  assign w_an  = an_in;
  assign w_seg = seg_in;
`endif

  // Exactly one anode low: non-zero and a power of two.
  assign w_low    = ~w_an;
  assign w_active = (w_low != '0) && ((w_low & (w_low - c_one)) == '0);
  assign w_same   = ({w_an, w_seg} == {r_prev_an, r_prev_seg});

  always_comb begin
    w_cnt_next = 8'd0;
    if (w_active) begin
      if (!w_same) begin
        w_cnt_next = 8'd1;
      end else if (r_cnt == c_stable) begin
        w_cnt_next = r_cnt;
      end else begin
        w_cnt_next = r_cnt + 8'd1;
      end
    end
  end

  // r_hit marks the single cycle in which the counter has just reached the threshold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev_an  <= '0;
      r_prev_seg <= '0;
      r_cnt      <= 8'd0;
      r_hit      <= 1'b0;
    end else begin
      r_prev_an  <= w_an;
      r_prev_seg <= w_seg;
      r_cnt      <= w_cnt_next;
      r_hit      <= (w_cnt_next == c_stable) && (r_cnt != c_stable);
    end
  end

  always_comb begin
    w_idx = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (!r_prev_an[i]) begin
        w_idx = c_idx_w'(i);
      end
    end
  end

  seg7_to_hex u_decode (
    .i_pattern (r_prev_seg),
    .o_nibble  (w_nibble),
    .o_legal   (w_legal),
    .o_blank   (w_blank)
  );

  assign w_frame_done = &r_captured;
  assign w_capture    = r_hit && w_legal;
  assign w_illegal    = r_hit && !w_legal && !w_blank;

  // A capture coinciding with the frame copy lands in the freshly cleared frame.
  always_comb begin
    w_captured_next = w_frame_done ? '0 : r_captured;
    if (w_capture) begin
      w_captured_next = w_captured_next | (c_one << w_idx);
    end
    if (w_illegal) begin
      w_captured_next = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_captured  <= '0;
      r_slots     <= '0;
      r_value     <= '0;
      r_valid     <= 1'b0;
      r_err       <= 1'b0;
      r_err_digit <= '0;
    end else begin
      r_captured <= w_captured_next;
      r_valid    <= w_frame_done;
      r_err      <= w_illegal;
      if (w_frame_done) begin
        r_value <= r_slots;
      end
      if (w_capture) begin
        r_slots[w_idx*4 +: 4] <= w_nibble;
      end
      if (w_illegal) begin
        r_err_digit <= w_idx;
      end
    end
  end

  assign value_out = r_value;
  assign valid_out = r_valid;
  assign err_out   = r_err;
  assign err_digit = r_err_digit;

endmodule

`default_nettype wire

// File: doc/seven_segment_reader.md
SEVEN_SEGMENT_READER -- requirements
Module: seven_segment_reader

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4: number of multiplexed digit positions observed.
REQ-002 SHALL have parameter STABLE_CYCLES, default 4, range 2..255: consecutive identical samples required before a digit is captured.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port an_in  input  NUM_DIGITS  digit anode strobes, active-low; bit i selects digit i.
REQ-006 SHALL have port seg_in  input  7  segment lines, active-low, bit6=a through bit0=g.
REQ-007 SHALL have port value_out  output  4*NUM_DIGITS  last complete frame; digit i in bits [4i+3:4i].
REQ-008 SHALL have port valid_out  output  1  one-cycle pulse when value_out updates.
REQ-009 SHALL have port err_out  output  1  one-cycle pulse on a stable illegal pattern.
REQ-010 SHALL have port err_digit  output  $clog2(NUM_DIGITS)  digit index of the latest err_out pulse, held until the next pulse.

Function
REQ-011 SHALL treat a sample as active only when exactly one an_in bit is low; zero or multiple low bits clear the stability counter.
REQ-012 SHALL increment the stability counter while {an_in, seg_in} equals the previous sample and reset it to 1 on any change.
REQ-013 SHALL evaluate a digit exactly once, in the cycle the counter reaches STABLE_CYCLES; the counter saturates with no re-evaluation until the inputs change.
REQ-014 SHALL decode the 16 hex patterns: 0=7'h01, 1=7'h4F, 2=7'h12, 3=7'h06, 4=7'h4C, 5=7'h24, 6=7'h20, 7=7'h0F, 8=7'h00, 9=7'h04, A=7'h08, b=7'h60, C=7'h31, d=7'h42, E=7'h30, F=7'h38.
REQ-015 SHALL, on a legal evaluated pattern, write the nibble into digit slot i and set captured[i]; re-capturing a slot overwrites it.
REQ-016 SHALL ignore blank pattern 7'h7F: no capture, no error.
REQ-017 SHALL, on any other evaluated pattern, pulse err_out for one cycle the following cycle, load err_digit, and clear all captured bits (frame discarded).
REQ-018 SHALL, in the cycle after captured becomes all ones, copy all slots to value_out, pulse valid_out, and clear captured.
REQ-019 SHALL give a latency of STABLE_CYCLES+1 cycles from the last digit's first stable sample to valid_out, without the synchronizer.
REQ-020 SHALL let a capture arriving in the same cycle as the frame copy go into the next frame, not the current one.

Reset
REQ-021 SHALL, when rst_n is low, asynchronously clear value_out, valid_out, err_out, err_digit, captured, slots, counter and previous-sample registers to zero.
REQ-022 SHALL, after a reset mid-frame, start a fresh frame with no partial capture retained.

Configuration
REQ-023 SHALL, with SEVEN_SEG_READER_SYNC_EN defined, pass an_in and seg_in through a two-flop synchronizer (reset to all ones), adding 2 cycles latency.
REQ-024 SHALL, without SEVEN_SEG_READER_SYNC_EN, sample an_in and seg_in directly.

Structure
REQ-025 SHALL place the 16 segment-pattern constants, the blank constant 7'h7F and the segment bit-order definition in package seven_seg_pkg.
REQ-026 SHALL contain one combinational sub-module seg7_to_hex: 7-bit pattern in; 4-bit nibble, legal flag and blank flag out.

Verification
REQ-027 SHALL cover: scan digits 0..3 as 4,3,2,1 (an_in 4'b1110,1101,1011,0111; seg 7'h4C,06,12,4F), 8 cycles each -> value_out=16'h1234 and a single valid_out pulse 5 cycles after digit 3's first sample.
REQ-028 SHALL cover: digit 2 held at 7'h55 for 8 cycles mid-frame -> one err_out pulse, err_digit=2, no valid_out for that frame.
REQ-029 SHALL cover: each digit held only 3 cycles (STABLE_CYCLES=4) -> no capture, no valid_out.
REQ-030 SHALL cover: an_in=4'b1100 with seg 7'h08 for 10 cycles -> no capture, no error.
REQ-031 SHALL cover: rst_n pulsed low after 2 of 4 digits, then a full frame 'F' 'A' 'b' 'C' -> value_out=16'hCbAF, with no stale digits.
REQ-032 SHALL cover: blank 7'h7F on digit 1 for 8 cycles -> no err_out, captured[1] unchanged.
